// File: rtl/hd_timing_pkg.sv
// hd_pkg: shared beat encodings, state type, phase count and the
// beat-sequencing helper for the hd_timing block.
package hd_pkg;

  // One-hot beat encodings as driven on W[3:1]
  localparam logic [2:0] W_B1 = 3'b001;
  localparam logic [2:0] W_B2 = 3'b010;
  localparam logic [2:0] W_B3 = 3'b100;

  // Number of phase strobes (T1..T3) in one beat
  localparam int unsigned PHASE_COUNT = 3;

  // One-hot phase encodings; PH_LEAD is the empty slot between a start
  // request and the first T1
  localparam logic [PHASE_COUNT-1:0] PH_LEAD = 3'b000;
  localparam logic [PHASE_COUNT-1:0] PH_T1   = 3'b001;
  localparam logic [PHASE_COUNT-1:0] PH_T2   = 3'b010;
  localparam logic [PHASE_COUNT-1:0] PH_T3   = 3'b100;

  // Top-level control state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } hd_state_t;

  // Beat that follows cur at a beat boundary. SHORT wins over LONG in W1,
  // LONG only matters in W2, W3 always returns to W1. An illegal beat
  // encoding recovers to W1.
  function automatic logic [2:0] next_beat(input logic [2:0] cur,
                                           input logic       short_req,
                                           input logic       long_req);
    logic [2:0] nb;
    case (cur)
      W_B1:    nb = short_req ? W_B1 : W_B2;
      W_B2:    nb = long_req  ? W_B3 : W_B1;
      W_B3:    nb = W_B1;
      default: nb = W_B1;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/hd_timing_sync.sv
// hd_sync: SYNC_STAGES-deep input synchronizer followed by a rising-edge
// detector. OUT_LEVEL selects whether o_out is the synchronized level or
// the one-cycle rising-edge pulse.
// A validity shadow chain marks which synchronizer stages hold real samples
// since reset, so an input already high when reset is released is not
// mistaken for a fresh rising edge.
module hd_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit OUT_LEVEL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_out
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic                   r_prev;
  logic                   r_prev_vld;
  logic                   w_level;
  logic                   w_rise;

  // Shift the asynchronous input (and its validity tag) through the chain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync     <= '0;
      r_vld      <= '0;
      r_prev     <= 1'b0;
      r_prev_vld <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_vld      <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      r_prev     <= r_sync[SYNC_STAGES-1];
      r_prev_vld <= r_vld[SYNC_STAGES-1];
    end
  end

  assign w_level = r_sync[SYNC_STAGES-1] & r_vld[SYNC_STAGES-1];
  assign w_rise  = r_sync[SYNC_STAGES-1] & ~r_prev & r_prev_vld;
  assign o_out   = OUT_LEVEL ? w_level : w_rise;

endmodule

// File: rtl/hd_timing.sv
// hd_timing: beat/phase timing generator. Produces T1/T2/T3 phase strobes
// inside one-hot beats W1/W2/W3, started by a QD push-button edge and
// steered at each beat boundary by SHORT/LONG/STOP. Also latches a
// synchronized interrupt request cleared by INTA during T3.
// Optional feature macro: HD_TIMING_SINGLE_STEP_EN (adds SSTEP input; while
// SSTEP is high every beat boundary behaves as a STOP).
module hd_timing
  import hd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       QD,
  input  logic       SHORT,
  input  logic       LONG,
  input  logic       STOP,
  input  logic       PULSE,
  input  logic       INTA,
`ifdef HD_TIMING_SINGLE_STEP_EN
  input  logic       SSTEP,
`endif
  output logic       T1,
  output logic       T2,
  output logic       T3,
  output logic [3:1] W,
  output logic       RUN,
  output logic       PULSE_REQ
);

  hd_state_t              r_state;
  logic [PHASE_COUNT-1:0] r_phase;
  logic [2:0]             r_beat;
  logic                   r_req;

  hd_state_t              w_state_nxt;
  logic [PHASE_COUNT-1:0] w_phase_nxt;
  logic [2:0]             w_beat_nxt;
  logic                   w_req_nxt;
  logic                   w_boundary;
  logic                   w_halt;
  logic                   w_qd_rise;
  logic                   w_pulse_rise;
  logic                   w_step;

  hd_sync #(.SYNC_STAGES(SYNC_STAGES), .OUT_LEVEL(1'b0)) u_sync_qd (
    .i_clk   (CLK),
    .i_rst_n (CLR),
    .i_async (QD),
    .o_out   (w_qd_rise)
  );

  hd_sync #(.SYNC_STAGES(SYNC_STAGES), .OUT_LEVEL(1'b0)) u_sync_pulse (
    .i_clk   (CLK),
    .i_rst_n (CLR),
    .i_async (PULSE),
    .o_out   (w_pulse_rise)
  );

`ifdef HD_TIMING_SINGLE_STEP_EN
  hd_sync #(.SYNC_STAGES(SYNC_STAGES), .OUT_LEVEL(1'b1)) u_sync_sstep (
    .i_clk   (CLK),
    .i_rst_n (CLR),
    .i_async (SSTEP),
    .o_out   (w_step)
  );
`else
  assign w_step = 1'b0;
`endif

  // The edge that ends T3 is the only point where controller requests count
  assign w_boundary = (r_state == ST_RUN) && (r_phase == PH_T3);
  assign w_halt     = STOP | w_step;

  // Next-state logic for state, phase and beat
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_beat_nxt  = r_beat;
    case (r_state)
      ST_IDLE: begin
        w_phase_nxt = PH_LEAD;
        if (w_qd_rise) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        case (r_phase)
          PH_LEAD: w_phase_nxt = PH_T1;
          PH_T1:   w_phase_nxt = PH_T2;
          PH_T2:   w_phase_nxt = PH_T3;
          PH_T3: begin
            w_beat_nxt = next_beat(r_beat, SHORT, LONG);
            if (w_halt) begin
              w_state_nxt = ST_IDLE;
              w_phase_nxt = PH_LEAD;
            end else begin
              w_phase_nxt = PH_T1;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_phase_nxt = PH_LEAD;
          end
        endcase
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = PH_LEAD;
      end
    endcase
  end

  // Interrupt request: a new edge always wins over an acknowledge
  always_comb begin
    w_req_nxt = r_req;
    if (w_pulse_rise) begin
      w_req_nxt = 1'b1;
    end else if (w_boundary && INTA) begin
      w_req_nxt = 1'b0;
    end else begin
      w_req_nxt = r_req;
    end
  end

  // State, phase, beat and request registers
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= ST_IDLE;
      r_phase <= PH_LEAD;
      r_beat  <= W_B1;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_beat  <= w_beat_nxt;
      r_req   <= w_req_nxt;
    end
  end

  assign T1        = r_phase[0];
  assign T2        = r_phase[1];
  assign T3        = r_phase[2];
  assign W         = r_beat;
  assign RUN       = (r_state == ST_RUN);
  assign PULSE_REQ = r_req;

endmodule

// File: tb/tb_hd_timing.sv
// Directed self-checking bench for hd_timing (SYNC_STAGES = 2).
module tb_hd_timing;

  localparam int NS = 2;

  logic       CLK   = 1'b0;
  logic       CLR   = 1'b0;
  logic       QD    = 1'b0;
  logic       SHORT = 1'b0;
  logic       LONG  = 1'b0;
  logic       STOP  = 1'b0;
  logic       PULSE = 1'b0;
  logic       INTA  = 1'b0;
  logic       SSTEP = 1'b0;
  logic       T1, T2, T3, RUN, PULSE_REQ;
  logic [3:1] W;
  logic [2:0] t_vec;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  assign t_vec = {T3, T2, T1};

  hd_timing #(.SYNC_STAGES(NS)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .QD        (QD),
    .SHORT     (SHORT),
    .LONG      (LONG),
    .STOP      (STOP),
    .PULSE     (PULSE),
    .INTA      (INTA),
`ifdef HD_TIMING_SINGLE_STEP_EN
    .SSTEP     (SSTEP),
`endif
    .T1        (T1),
    .T2        (T2),
    .T3        (T3),
    .W         (W),
    .RUN       (RUN),
    .PULSE_REQ (PULSE_REQ)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b0;
    repeat (3) tick();
    n_chk++; if (W !== 3'b001) $display("FAIL rst_w: got %b want 001", W); else n_pass++;
    n_chk++; if (t_vec !== 3'b000) $display("FAIL rst_t: got %b want 000", t_vec); else n_pass++;
    n_chk++; if (RUN !== 1'b0) $display("FAIL rst_run: got %b want 0", RUN); else n_pass++;
    n_chk++; if (PULSE_REQ !== 1'b0) $display("FAIL rst_preq: got %b want 0", PULSE_REQ); else n_pass++;
    CLR = 1'b1;
    repeat (5) tick();
    n_chk++; if ({RUN, t_vec} !== 4'b0000) $display("FAIL rst_idle: got %b want 0000", {RUN, t_vec}); else n_pass++;
  endtask

  task automatic test_free_run();
    logic [2:0] exp_w;
    logic [2:0] exp_t;
    QD = 1'b1;
    tick(); tick();
    n_chk++; if (RUN !== 1'b0) $display("FAIL start_early: got %b want 0", RUN); else n_pass++;
    tick();
    n_chk++; if ({RUN, t_vec} !== 4'b1000) $display("FAIL start_run: got %b want 1000", {RUN, t_vec}); else n_pass++;
    for (int b = 0; b < 4; b++) begin
      exp_w = (b % 2 == 0) ? 3'b001 : 3'b010;
      for (int p = 0; p < 3; p++) begin
        tick();
        exp_t = 3'b001 << p;
        n_chk++;
        if ({W, t_vec} !== {exp_w, exp_t})
          $display("FAIL free_run b%0d p%0d: got W=%b T=%b want W=%b T=%b", b, p, W, t_vec, exp_w, exp_t);
        else n_pass++;
      end
    end
  endtask

  // Entered at W2 T3
  task automatic test_long();
    LONG = 1'b1;
    tick();
    LONG = 1'b0;
    n_chk++; if ({W, t_vec} !== 6'b100_001) $display("FAIL long_w3: got W=%b T=%b want W=100 T=001", W, t_vec); else n_pass++;
    tick(); tick();
    n_chk++; if ({W, t_vec} !== 6'b100_100) $display("FAIL long_w3t3: got W=%b T=%b want W=100 T=100", W, t_vec); else n_pass++;
    SHORT = 1'b1;
    LONG  = 1'b1;
    tick();
    n_chk++; if ({W, t_vec} !== 6'b001_001) $display("FAIL w3_to_w1: got W=%b T=%b want W=001 T=001", W, t_vec); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (W !== 3'b001) $display("FAIL short_prio %0d: got W=%b want 001", i, W); else n_pass++;
    end
  endtask

  // Entered at W1 T3 with SHORT = LONG = 1, QD still held high
  task automatic test_stop();
    STOP = 1'b1;
    tick();
    STOP  = 1'b0;
    SHORT = 1'b0;
    LONG  = 1'b0;
    n_chk++; if ({RUN, W, t_vec} !== 7'b0_001_000) $display("FAIL stop: got RUN=%b W=%b T=%b want RUN=0 W=001 T=000", RUN, W, t_vec); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_chk++; if ({RUN, t_vec} !== 4'b0000) $display("FAIL stop_hold %0d: got %b want 0000", i, {RUN, t_vec}); else n_pass++;
    end
    QD = 1'b0;
    repeat (4) tick();
    QD = 1'b1;
    tick(); tick();
    n_chk++; if (RUN !== 1'b0) $display("FAIL restart_early: got %b want 0", RUN); else n_pass++;
    tick();
    n_chk++; if ({RUN, t_vec} !== 4'b1000) $display("FAIL restart_run: got %b want 1000", {RUN, t_vec}); else n_pass++;
    tick();
    n_chk++; if ({W, t_vec} !== 6'b001_001) $display("FAIL restart_t1: got W=%b T=%b want W=001 T=001", W, t_vec); else n_pass++;
  endtask

  // Entered at W1 T1
  task automatic test_pulse();
    PULSE = 1'b1;
    tick(); tick();
    n_chk++; if (PULSE_REQ !== 1'b0) $display("FAIL preq_early: got %b want 0", PULSE_REQ); else n_pass++;
    tick();
    n_chk++; if (PULSE_REQ !== 1'b1) $display("FAIL preq_set: got %b want 1", PULSE_REQ); else n_pass++;
    INTA = 1'b1;
    tick(); tick();
    n_chk++; if ({PULSE_REQ, t_vec} !== 4'b1100) $display("FAIL preq_t3: got %b want 1100", {PULSE_REQ, t_vec}); else n_pass++;
    tick();
    n_chk++; if (PULSE_REQ !== 1'b0) $display("FAIL preq_clr: got %b want 0", PULSE_REQ); else n_pass++;
    INTA  = 1'b0;
    PULSE = 1'b0;
    repeat (3) tick();
    n_chk++; if ({PULSE_REQ, t_vec} !== 4'b0001) $display("FAIL preq_idle: got %b want 0001", {PULSE_REQ, t_vec}); else n_pass++;
    PULSE = 1'b1;
    INTA  = 1'b1;
    tick(); tick();
    n_chk++; if (PULSE_REQ !== 1'b0) $display("FAIL preq_pre_coll: got %b want 0", PULSE_REQ); else n_pass++;
    tick();
    n_chk++; if (PULSE_REQ !== 1'b1) $display("FAIL preq_set_wins: got %b want 1", PULSE_REQ); else n_pass++;
    INTA = 1'b0;
  endtask

  task automatic test_clr_mid_beat();
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (W === 3'b010 && t_vec === 3'b010) found = 1'b1;
    end
    n_chk++; if (found !== 1'b1) $display("FAIL find_w2t2: got %b want 1", found); else n_pass++;
    CLR = 1'b0;
    #1;
    n_chk++;
    if ({RUN, W, t_vec, PULSE_REQ} !== 8'b0_001_000_0)
      $display("FAIL clr_async: got RUN=%b W=%b T=%b PREQ=%b want 0 001 000 0", RUN, W, t_vec, PULSE_REQ);
    else n_pass++;
    PULSE = 1'b0;
    tick(); tick();
    n_chk++; if ({RUN, t_vec} !== 4'b0000) $display("FAIL clr_held: got %b want 0000", {RUN, t_vec}); else n_pass++;
    CLR = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++; if ({RUN, t_vec} !== 4'b0000) $display("FAIL qd_held_release %0d: got %b want 0000", i, {RUN, t_vec}); else n_pass++;
    end
    QD = 1'b0;
    repeat (4) tick();
    QD = 1'b1;
    repeat (3) tick();
    n_chk++; if (RUN !== 1'b1) $display("FAIL clr_restart_run: got %b want 1", RUN); else n_pass++;
    tick();
    n_chk++; if ({W, t_vec} !== 6'b001_001) $display("FAIL clr_restart_t1: got W=%b T=%b want W=001 T=001", W, t_vec); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_long();
    test_stop();
    test_pulse();
    test_clr_mid_beat();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
